apb_core_master: RTL and testbench
==================================

APB_CORE_MASTER -- requirements
Module: apb_core_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set request and PADDR address width.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set write-data and read-data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum ACCESS-phase wait; 0 SHALL disable the timeout.
REQ-004 clk  input  1  clock; all logic SHALL be rising-edge triggered.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  core requests a transfer.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_WIDTH  transfer address.
REQ-009 req_wdata  input  DATA_WIDTH  write data.
REQ-010 req_ready  output  1  block can accept a request this cycle.
REQ-011 rsp_valid  output  1  one-cycle pulse marking transfer completion.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  transfer aborted by timeout; qualified by rsp_valid.
REQ-014 M_PADDR, M_PWRITE, M_PSELx (1 bit), M_PENABLE, M_PWDATA  outputs  APB master signals toward the interconnect slave port.
REQ-015 M_PRDATA  input  DATA_WIDTH;  M_PREADY  input  1  APB response.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS; reset state IDLE.
REQ-017 req_ready SHALL be 1 exactly when state is IDLE and reset is low.
REQ-018 Request SHALL be accepted when req_valid && req_ready; req_write, req_addr, req_wdata SHALL be captured into registers at that edge, and the FSM SHALL enter SETUP.
REQ-019 SETUP: M_PSELx=1, M_PENABLE=0 for exactly one cycle, then ACCESS unconditionally.
REQ-020 ACCESS: M_PSELx=1, M_PENABLE=1 until M_PREADY is sampled high or timeout.
REQ-021 M_PADDR, M_PWRITE, M_PWDATA SHALL be driven from the captured registers and SHALL be stable from SETUP through the final ACCESS cycle.
REQ-022 On M_PREADY=1 in ACCESS: next state IDLE; at that edge rsp_valid<=1, rsp_err<=0, rsp_rdata<=(read ? M_PRDATA : 0).
REQ-023 rsp_valid SHALL be high for exactly one cycle per accepted request.
REQ-024 Latency: accept at edge N -> SETUP cycle N+1 -> ACCESS N+2; PREADY at N+2 -> rsp_valid in cycle N+3.
REQ-025 A new request SHALL be acceptable in the same cycle rsp_valid is high (back-to-back, 3-cycle minimum issue interval).
REQ-026 Wait counter SHALL clear on SETUP entry and increment each ACCESS cycle without PREADY; width clog2(TIMEOUT_CYCLES+1), never wrapping.
REQ-027 When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with PREADY low: next state IDLE, M_PSELx/M_PENABLE drop, rsp_valid<=1, rsp_err<=1, rsp_rdata<=0.
REQ-028 PREADY sampled high in the same cycle timeout is reached SHALL win (normal completion, rsp_err=0).
REQ-029 M_PSELx and M_PENABLE SHALL be 0 in IDLE; M_PREADY SHALL be ignored outside ACCESS.
REQ-030 Extended M_PREADY low (e.g. arbitration wait in the interconnect) SHALL hold ACCESS with all APB outputs unchanged.

Reset
REQ-031 On reset: state IDLE, M_PSELx=0, M_PENABLE=0, M_PADDR=0, M_PWRITE=0, M_PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter 0.
REQ-032 Reset mid-transfer SHALL abort silently: no rsp_valid for the aborted request, APB outputs low at the next edge.

Structure
REQ-033 State encodings SHALL be local parameters; only the default ADDR/DATA widths and default timeout SHALL come from vmicro16_soc_config.v.
REQ-034 Counter width SHALL use the shared clog2 macro; no sub-module is required.

Verification
REQ-035 Read: req addr 0x0010, slave PREADY in first ACCESS cycle, PRDATA 0xBEEF -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_rdata 0xBEEF, rsp_err 0.
REQ-036 Write: addr 0x0020, wdata 0x1234, PREADY after 3 wait cycles -> PADDR/PWDATA stable for 5 cycles, rsp_valid once, rsp_rdata 0.
REQ-037 Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL drops after 4 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata 0.
REQ-038 Back-to-back: req_valid held high for two reads, PREADY immediate -> second accept in first rsp_valid cycle, responses 3 cycles apart.
REQ-039 Reset during ACCESS -> PSEL/PENABLE 0 next cycle, no rsp_valid, req_ready 1 after reset release.
REQ-040 PREADY and timeout in the same cycle (TIMEOUT_CYCLES=2, PREADY on second ACCESS cycle) -> rsp_err 0, data returned.

Source files
------------

// File: rtl/apb_core_master_pkg.sv
// Shared defaults and helpers for the APB core master.
package apb_core_master_pkg;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Ceiling log2 that never returns zero, so counters keep at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_core_master.sv
// Single-outstanding APB master: turns core requests into SETUP/ACCESS
// transfers and returns a one-cycle response, with optional wait timeout.
module apb_core_master
  import apb_core_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // The final ACCESS cycle is the one in which the counter still holds
  // TIMEOUT_CYCLES-1; the abort lands at the edge that ends it.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             timeout_hit;

  assign req_ready   = (state == ST_IDLE) && !reset;
  assign accept      = req_valid && req_ready;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);
  assign M_PSELx     = (state == ST_SETUP) || (state == ST_ACCESS);
  assign M_PENABLE   = (state == ST_ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PWDATA  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SETUP;
            wait_cnt <= '0;
            M_PADDR  <= req_addr;
            M_PWRITE <= req_write;
            M_PWDATA <= req_wdata;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          // PREADY takes priority over a timeout reached in the same cycle.
          if (M_PREADY) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= M_PWRITE ? '0 : M_PRDATA;
          end else if (timeout_hit) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_core_master.sv
// Scoreboard bench for apb_core_master with a simple APB slave model.
module tb_apb_core_master;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] M_PADDR;
  logic          M_PWRITE, M_PSELx, M_PENABLE;
  logic [DW-1:0] M_PWDATA;
  logic [DW-1:0] M_PRDATA;
  logic          M_PREADY;

  always #5 clk = ~clk;

  apb_core_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: PREADY after slave_wait extra ACCESS cycles (-1 = never); read
  // data is the address xor a key. Outside ACCESS it drives PREADY high
  // with junk data, which the master must ignore.
  int            slave_wait = 0;
  logic [DW-1:0] slave_key  = 16'hBEFF;
  int            acc_cnt    = 0;
  always @(negedge clk) begin
    if (M_PSELx && M_PENABLE) begin
      M_PREADY = (slave_wait >= 0) && (acc_cnt == slave_wait);
      M_PRDATA = M_PADDR ^ slave_key;
      acc_cnt++;
    end else begin
      M_PREADY = 1'b1;
      M_PRDATA = 16'hDEAD;
      acc_cnt  = 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rsp_cnt = 0, rsp_cyc = 0, prev_rsp_cyc = 0;
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      rsp_t e;
      rsp_cnt++;
      prev_rsp_cyc = rsp_cyc;
      rsp_cyc      = cyc;
      if (rsp_cnt > 1) check("rsp_gap_ge3", 32'(rsp_cyc - prev_rsp_cyc >= 3), 1);
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic exp_err, input logic [DW-1:0] exp_rdata,
                       input bit hold, output int acc_cyc);
    int   waited;
    rsp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 1);
    e.err   = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, base, n;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    M_PREADY = 1'b0; M_PRDATA = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_psel", 32'(M_PSELx), 0);
    check("rst_penable", 32'(M_PENABLE), 0);
    check("rst_paddr", 32'(M_PADDR), 0);
    check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 1);

    // Read, PREADY on first ACCESS cycle
    slave_wait = 0; slave_key = 16'hBEFF;
    issue(1'b0, 16'h0010, 16'h0, 1'b0, 16'hBEEF, 1'b0, acc);
    @(negedge clk);
    check("rd_setup_psel", 32'({M_PSELx, M_PENABLE}), 32'h2);
    check("rd_setup_paddr", 32'(M_PADDR), 32'h0010);
    @(negedge clk);
    check("rd_access", 32'({M_PSELx, M_PENABLE}), 32'h3);
    @(negedge clk);
    check("rd_rsp_valid", 32'(rsp_valid), 1);
    check("rd_idle_psel", 32'(M_PSELx), 0);
    #1;
    check("rd_latency", 32'(rsp_cyc - acc), 2);

    // Write with three wait cycles; PREADY coincides with the timeout cycle
    slave_wait = 3;
    base = rsp_cnt;
    issue(1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0, 1'b0, acc);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!M_PSELx) break;
      n++;
      check("wr_paddr", 32'(M_PADDR), 32'h0020);
      check("wr_pwdata", 32'(M_PWDATA), 32'h1234);
      check("wr_pwrite", 32'(M_PWRITE), 1);
    end
    check("wr_psel_cycles", 32'(n), 5);
    repeat (3) @(negedge clk);
    #1;
    check("wr_rsp_once", 32'(rsp_cnt - base), 1);

    // Read completing in the same cycle the timeout would fire
    slave_wait = 3; slave_key = 16'h1111;
    issue(1'b0, 16'h0024, 16'h0, 1'b0, 16'h0024 ^ 16'h1111, 1'b0, acc);
    repeat (7) @(negedge clk);

    // Timeout: slave never ready
    slave_wait = -1;
    issue(1'b0, 16'h0030, 16'h0, 1'b1, 16'h0, 1'b0, acc);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (M_PENABLE) n++;
      else if (n > 0) break;
    end
    check("to_access_cycles", 32'(n), TO);
    check("to_psel_drop", 32'(M_PSELx), 0);
    check("to_rsp_valid", 32'(rsp_valid), 1);
    @(negedge clk);

    // Back-to-back reads with req_valid held high
    slave_wait = 0; slave_key = 16'h5A00;
    issue(1'b0, 16'h0040, 16'h0, 1'b0, 16'h0040 ^ 16'h5A00, 1'b1, acc);
    issue(1'b0, 16'h0042, 16'h0, 1'b0, 16'h0042 ^ 16'h5A00, 1'b0, acc2);
    check("b2b_accept", 32'(acc2 - acc), 3);
    repeat (3) @(negedge clk);
    #1;
    check("b2b_rsp_gap", 32'(rsp_cyc - prev_rsp_cyc), 3);

    // Reset during ACCESS aborts silently
    slave_wait = -1;
    issue(1'b1, 16'h0050, 16'hABCD, 1'b0, 16'h0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_in_access", 32'(M_PENABLE), 1);
    base = rsp_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_psel", 32'({M_PSELx, M_PENABLE}), 0);
    check("rst_mid_paddr", 32'(M_PADDR), 0);
    check("rst_mid_pwdata", 32'(M_PWDATA), 0);
    check("rst_mid_rsp", 32'(rsp_valid), 0);
    check("rst_mid_ready", 32'(req_ready), 0);
    reset = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_ready_rel", 32'(req_ready), 1);
    repeat (5) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_cnt - base), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
